// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter sequencing accesses to the single-port dmem syncram
module dmem_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_wren,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_data,
    output logic              p0_gnt,
    output logic              p0_done,
    output logic [DATA_W-1:0] p0_q,
    input  logic              p1_req,
    input  logic              p1_wren,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_data,
    output logic              p1_gnt,
    output logic              p1_done,
    output logic [DATA_W-1:0] p1_q,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             winner;
    logic             last_gnt;
    logic             any_req;
    logic             arb_pick;
    logic             wait_last;
    logic [CNT_W-1:0] wait_cnt;

    // Contention goes to the port that did not win last time.
    always_comb begin
        any_req  = p0_req | p1_req;
        arb_pick = 1'b0;
        if (p0_req && p1_req) begin
            arb_pick = ~last_gnt;
        end else if (p1_req) begin
            arb_pick = 1'b1;
        end
    end

    assign wait_last = (wait_cnt == '0);

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:   if (any_req) state_next = S_ACCESS;
            S_ACCESS: state_next = mem_wren ? S_DONE : S_WAIT;
            S_WAIT:   if (wait_last) state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // All outputs are registered so each pulse lines up with the state it belongs to.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            p0_gnt      <= 1'b0;
            p1_gnt      <= 1'b0;
            p0_done     <= 1'b0;
            p1_done     <= 1'b0;
            p0_q        <= '0;
            p1_q        <= '0;
            mem_address <= '0;
            mem_data    <= '0;
            mem_wren    <= 1'b0;
            winner      <= 1'b0;
            last_gnt    <= 1'b1;
            wait_cnt    <= '0;
        end else begin
            p0_gnt   <= 1'b0;
            p1_gnt   <= 1'b0;
            p0_done  <= 1'b0;
            p1_done  <= 1'b0;
            mem_wren <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        winner      <= arb_pick;
                        last_gnt    <= arb_pick;
                        p0_gnt      <= ~arb_pick;
                        p1_gnt      <= arb_pick;
                        mem_address <= arb_pick ? p1_addr : p0_addr;
                        mem_data    <= arb_pick ? p1_data : p0_data;
                        mem_wren    <= arb_pick ? p1_wren : p0_wren;
                    end
                end
                S_ACCESS: begin
                    wait_cnt <= CNT_W'(READ_LAT - 1);
                    if (mem_wren) begin
                        p0_done <= ~winner;
                        p1_done <= winner;
                    end
                end
                S_WAIT: begin
                    if (wait_last) begin
                        if (winner) begin
                            p1_q <= mem_q;
                        end else begin
                            p0_q <= mem_q;
                        end
                        p0_done <= ~winner;
                        p1_done <= winner;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized self-checking bench for dmem_arbiter at READ_LAT 1, 2 and 3
module tb_dmem_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int NI = 3;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } txn_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          p0_req [NI];
    logic          p0_wren[NI];
    logic [AW-1:0] p0_addr[NI];
    logic [DW-1:0] p0_data[NI];
    logic          p0_gnt [NI];
    logic          p0_done[NI];
    logic [DW-1:0] p0_q   [NI];
    logic          p1_req [NI];
    logic          p1_wren[NI];
    logic [AW-1:0] p1_addr[NI];
    logic [DW-1:0] p1_data[NI];
    logic          p1_gnt [NI];
    logic          p1_done[NI];
    logic [DW-1:0] p1_q   [NI];
    logic [AW-1:0] mem_address[NI];
    logic [DW-1:0] mem_data   [NI];
    logic          mem_wren   [NI];

    int            vectors = 0;
    int            miscompares = 0;
    txn_t          pend [2][$];
    logic [DW-1:0] model_mem [NI][4096];
    logic [DW-1:0] model_q [NI][2];
    int            last_gnt [NI];

    always #5 clock = ~clock;

    // Instance g runs with READ_LAT = g+1 against its own syncram model.
    for (genvar g = 0; g < NI; g++) begin : g_inst
        logic [DW-1:0] ram [4096];
        logic [DW-1:0] q_pipe [g+1];

        always @(posedge clock) begin
            if (mem_wren[g]) ram[mem_address[g]] <= mem_data[g];
            q_pipe[0] <= ram[mem_address[g]];
            for (int i = 1; i <= g; i++) q_pipe[i] <= q_pipe[i-1];
        end

        dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(g + 1)) dut (
            .clock      (clock),
            .reset      (reset),
            .p0_req     (p0_req[g]),
            .p0_wren    (p0_wren[g]),
            .p0_addr    (p0_addr[g]),
            .p0_data    (p0_data[g]),
            .p0_gnt     (p0_gnt[g]),
            .p0_done    (p0_done[g]),
            .p0_q       (p0_q[g]),
            .p1_req     (p1_req[g]),
            .p1_wren    (p1_wren[g]),
            .p1_addr    (p1_addr[g]),
            .p1_data    (p1_data[g]),
            .p1_gnt     (p1_gnt[g]),
            .p1_done    (p1_done[g]),
            .p1_q       (p1_q[g]),
            .mem_address(mem_address[g]),
            .mem_data   (mem_data[g]),
            .mem_wren   (mem_wren[g]),
            .mem_q      (q_pipe[g])
        );
    end

    task automatic chk(input int k, input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL k%0d %s: observed %h expected %h", k, tag, obs, exp);
        end
    endtask

    task automatic chk_hs(input int k, input string ph, input logic [1:0] g, input logic [1:0] dn);
        chk(k, {ph, " p0_gnt"}, DW'(p0_gnt[k]), DW'(g[0]));
        chk(k, {ph, " p1_gnt"}, DW'(p1_gnt[k]), DW'(g[1]));
        chk(k, {ph, " p0_done"}, DW'(p0_done[k]), DW'(dn[0]));
        chk(k, {ph, " p1_done"}, DW'(p1_done[k]), DW'(dn[1]));
    endtask

    task automatic chk_zero(input int k, input string ph);
        chk_hs(k, ph, 2'b00, 2'b00);
        chk(k, {ph, " p0_q"}, p0_q[k], '0);
        chk(k, {ph, " p1_q"}, p1_q[k], '0);
        chk(k, {ph, " mem_wren"}, DW'(mem_wren[k]), '0);
        chk(k, {ph, " mem_address"}, DW'(mem_address[k]), '0);
        chk(k, {ph, " mem_data"}, mem_data[k], '0);
    endtask

    task automatic drive(input int k);
        for (int p = 0; p < 2; p++) begin
            txn_t t;
            logic r;
            t = '0;
            r = (pend[p].size() != 0);
            if (r) t = pend[p][0];
            if (p == 0) begin
                p0_req[k] = r; p0_wren[k] = t.wr; p0_addr[k] = t.a; p0_data[k] = t.d;
            end else begin
                p1_req[k] = r; p1_wren[k] = t.wr; p1_addr[k] = t.a; p1_data[k] = t.d;
            end
        end
    endtask

    // Serve both pending queues on instance k, predicting each grant and completion cycle.
    task automatic run(input int k);
        int   w;
        int   dur;
        txn_t t;
        while (pend[0].size() != 0 || pend[1].size() != 0) begin
            drive(k);
            if (pend[0].size() != 0 && pend[1].size() != 0) w = 1 - last_gnt[k];
            else w = (pend[0].size() != 0) ? 0 : 1;
            t = pend[w].pop_front();
            last_gnt[k] = w;
            dur = t.wr ? 2 : 3 + k;
            @(negedge clock);
            chk_hs(k, "access", (w == 1) ? 2'b10 : 2'b01, 2'b00);
            chk(k, "access mem_address", DW'(mem_address[k]), DW'(t.a));
            chk(k, "access mem_data", mem_data[k], t.d);
            chk(k, "access mem_wren", DW'(mem_wren[k]), DW'(t.wr));
            drive(k);
            for (int c = 2; c <= dur; c++) begin
                @(negedge clock);
                chk_hs(k, "busy", 2'b00, (c == dur) ? ((w == 1) ? 2'b10 : 2'b01) : 2'b00);
                chk(k, "busy mem_address", DW'(mem_address[k]), DW'(t.a));
                chk(k, "busy mem_wren", DW'(mem_wren[k]), '0);
            end
            if (t.wr) model_mem[k][t.a] = t.d;
            else model_q[k][w] = model_mem[k][t.a];
            chk(k, "done p0_q", p0_q[k], model_q[k][0]);
            chk(k, "done p1_q", p1_q[k], model_q[k][1]);
            @(negedge clock);
            chk_hs(k, "idle", 2'b00, 2'b00);
            chk(k, "idle mem_wren", DW'(mem_wren[k]), '0);
            chk(k, "idle mem_address", DW'(mem_address[k]), DW'(t.a));
        end
        drive(k);
    endtask

    task automatic push(input int p, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        txn_t t;
        t.wr = wr; t.a = a; t.d = d;
        pend[p].push_back(t);
    endtask

    task automatic rand_batch(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            push(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
        end
        run(k);
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            last_gnt[k] = 1;
            model_q[k][0] = '0;
            model_q[k][1] = '0;
        end
    endtask

    initial begin
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < NI; k++) drive(k);
        repeat (2) @(negedge clock);
        for (int k = 0; k < NI; k++) chk_zero(k, "reset");
        reset = 1'b1;
        @(negedge clock);

        // single write then single read of the same word from the other port
        push(0, 1'b1, 12'h010, 32'hDEAD_BEEF);
        run(0);
        push(1, 1'b0, 12'h010, 32'h0);
        run(0);

        // contention, then repeated contention
        push(0, 1'b1, 12'h020, 32'h1111_1111);
        push(1, 1'b1, 12'h021, 32'h2222_2222);
        run(0);
        push(0, 1'b1, 12'h022, 32'h3333_3333);
        push(0, 1'b0, 12'h021, 32'h0);
        push(1, 1'b1, 12'h023, 32'h4444_4444);
        push(1, 1'b0, 12'h020, 32'h0);
        run(0);

        // back-to-back on port 0 with read-back
        for (int i = 0; i < 4; i++) push(0, 1'b1, AW'(i), 32'hA5A5_0000 + DW'(i));
        for (int i = 0; i < 4; i++) push(0, 1'b0, AW'(i), 32'h0);
        run(0);

        // READ_LAT=2 read
        push(0, 1'b1, 12'h030, 32'hCAFE_F00D);
        push(0, 1'b0, 12'h030, 32'h0);
        run(1);

        for (int k = 0; k < NI; k++) begin
            for (int a = 0; a < 16; a++) push(a % 2, 1'b1, AW'(a), $urandom);
            run(k);
            for (int b = 0; b < 3; b++) rand_batch(k, 12);
        end

        // reset while instance 2 waits on a read and instance 0 is writing
        p0_req[2] = 1'b1; p0_wren[2] = 1'b0; p0_addr[2] = 12'h005;
        @(negedge clock);
        chk(2, "pre-reset p0_gnt", DW'(p0_gnt[2]), 32'd1);
        p0_req[2] = 1'b0;
        p1_req[0] = 1'b1; p1_wren[0] = 1'b1; p1_addr[0] = 12'h007; p1_data[0] = 32'h0BAD_F00D;
        @(negedge clock);
        chk(0, "pre-reset mem_wren", DW'(mem_wren[0]), 32'd1);
        chk(2, "pre-reset p0_done", DW'(p0_done[2]), 32'd0);
        p1_req[0] = 1'b0;
        #2 reset = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < NI; k++) chk_zero(k, "async reset");
        @(negedge clock);
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            chk_hs(2, "post-reset", 2'b00, 2'b00);
            chk_hs(0, "post-reset", 2'b00, 2'b00);
        end
        push(0, 1'b0, 12'h005, 32'h0);
        push(1, 1'b0, 12'h007, 32'h0);
        run(2);
        push(1, 1'b0, 12'h007, 32'h0);
        push(0, 1'b1, 12'h040, 32'h5555_AAAA);
        run(0);
        rand_batch(2, 10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
